// File: rtl/layer_compositor_pkg.sv
// Shared constants for the layer compositor and the sprite readers that feed it.
//   PIX_W_DEF      default bits per pixel (4:4:4 RGB)
//   KEY_COLOR_DEF  default transparent colour key for sprite layers
//   BG_COLOR_DEF   default fill colour when no layer is visible
//   LAYER_BG       index of the background layer (never keyed)
package layer_compositor_pkg;

    localparam int unsigned PIX_W_DEF      = 12;
    localparam int unsigned NUM_LAYERS_DEF = 4;
    localparam int unsigned CNT_W_DEF      = 16;
    localparam logic [11:0] KEY_COLOR_DEF  = 12'hF0F;
    localparam logic [11:0] BG_COLOR_DEF   = 12'h000;
    localparam int unsigned LAYER_BG       = 0;

endpackage

// File: rtl/layer_compositor_prio_enc.sv
// Combinational priority encoder over per-layer opacity.
//   opaque_i     one bit per layer, set when that layer shows a pixel
//   top_idx_o    highest-index opaque layer (0 when none)
//   any_hit_o    at least one layer is opaque
//   multi_hit_o  two or more sprite layers (excluding background) are opaque
module layer_prio_enc
    import layer_compositor_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = NUM_LAYERS_DEF
) (
    input  logic [NUM_LAYERS-1:0]         opaque_i,
    output logic [$clog2(NUM_LAYERS)-1:0] top_idx_o,
    output logic                          any_hit_o,
    output logic                          multi_hit_o
);

    localparam int unsigned IDX_W = $clog2(NUM_LAYERS);

    logic seen_sprite;

    // Later iterations overwrite earlier ones, so the highest index wins.
    always_comb begin
        top_idx_o   = '0;
        any_hit_o   = 1'b0;
        multi_hit_o = 1'b0;
        seen_sprite = 1'b0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (opaque_i[i]) begin
                top_idx_o = IDX_W'(i);
                any_hit_o = 1'b1;
                if (i != LAYER_BG) begin
                    multi_hit_o = multi_hit_o | seen_sprite;
                    seen_sprite = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/layer_compositor.sv
// N-layer pixel compositor: fixed priority with colour-key transparency,
// 2-cycle pipeline, per-frame double-buffered layer enables and a per-frame
// sprite collision counter.
//   clk, rst         clock, synchronous active-high reset
//   frame_start      first pixel of a frame (qualified by pix_valid_in)
//   pix_valid_in     pixels_in valid
//   layer_en         requested layer enables, taken at frame_start
//   pixels_in        layer i at [i*PIX_W +: PIX_W], layer 0 = background
//   pix_out          composited pixel
//   pix_valid_out    pix_valid_in delayed by 2
//   top_layer        index of the displayed layer (0 also for fill)
//   collision_count  collided-pixel total of the previous frame
//   collision_flag   collision_count != 0
module layer_compositor
    import layer_compositor_pkg::*;
#(
    parameter int unsigned      NUM_LAYERS = NUM_LAYERS_DEF,
    parameter int unsigned      PIX_W      = PIX_W_DEF,
    parameter logic [PIX_W-1:0] KEY_COLOR  = PIX_W'(KEY_COLOR_DEF),
    parameter logic [PIX_W-1:0] BG_COLOR   = PIX_W'(BG_COLOR_DEF),
    parameter int unsigned      CNT_W      = CNT_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          frame_start,
    input  logic                          pix_valid_in,
    input  logic [NUM_LAYERS-1:0]         layer_en,
    input  logic [NUM_LAYERS*PIX_W-1:0]   pixels_in,
    output logic [PIX_W-1:0]              pix_out,
    output logic                          pix_valid_out,
    output logic [$clog2(NUM_LAYERS)-1:0] top_layer,
    output logic [CNT_W-1:0]              collision_count,
    output logic                          collision_flag
);

    localparam int unsigned IDX_W = $clog2(NUM_LAYERS);
    localparam int unsigned BUS_W = NUM_LAYERS * PIX_W;

    logic [NUM_LAYERS-1:0] en_active_q;
    logic                  s1_valid_q;
    logic                  s1_fs_q;
    logic [NUM_LAYERS-1:0] s1_en_q;
    logic [BUS_W-1:0]      s1_pix_q;
    logic                  s2_valid_q;
    logic [PIX_W-1:0]      pix_q;
    logic [IDX_W-1:0]      top_q;
    logic [CNT_W-1:0]      running_q;
    logic [CNT_W-1:0]      count_q;
    logic                  flag_q;

    logic [NUM_LAYERS-1:0] eff_en;
    logic [NUM_LAYERS-1:0] opaque;
    logic [PIX_W-1:0]      layer_pix;
    logic [IDX_W-1:0]      win_idx;
    logic                  any_hit;
    logic                  multi_hit;
    logic [PIX_W-1:0]      pix_d;
    logic [CNT_W-1:0]      running_d;

    // New enables apply to the frame_start pixel itself.
    always_comb begin
        eff_en = frame_start ? layer_en : en_active_q;
    end

    // Background ignores the key; sprite layers are transparent on KEY_COLOR.
    always_comb begin
        opaque    = '0;
        layer_pix = '0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            layer_pix = s1_pix_q[i*PIX_W +: PIX_W];
            if (i == LAYER_BG) begin
                opaque[i] = s1_en_q[i];
            end else begin
                opaque[i] = s1_en_q[i] && (layer_pix != KEY_COLOR);
            end
        end
    end

    layer_prio_enc #(
        .NUM_LAYERS (NUM_LAYERS)
    ) u_prio_enc (
        .opaque_i    (opaque),
        .top_idx_o   (win_idx),
        .any_hit_o   (any_hit),
        .multi_hit_o (multi_hit)
    );

    // Winner mux and saturating collision accumulator.
    always_comb begin
        pix_d = BG_COLOR;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (any_hit && (IDX_W'(i) == win_idx)) begin
                pix_d = s1_pix_q[i*PIX_W +: PIX_W];
            end
        end

        running_d = running_q;
        if (s1_fs_q) begin
            running_d = CNT_W'(multi_hit);
        end else if (multi_hit && (running_q != {CNT_W{1'b1}})) begin
            running_d = running_q + CNT_W'(1);
        end
    end

    // Pipeline registers; data holds while its valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_active_q <= '0;
            s1_valid_q  <= 1'b0;
            s1_fs_q     <= 1'b0;
            s1_en_q     <= '0;
            s1_pix_q    <= '0;
            s2_valid_q  <= 1'b0;
            pix_q       <= '0;
            top_q       <= '0;
            running_q   <= '0;
            count_q     <= '0;
            flag_q      <= 1'b0;
        end else begin
            s1_valid_q <= pix_valid_in;
            s2_valid_q <= s1_valid_q;
            if (pix_valid_in) begin
                s1_pix_q <= pixels_in;
                s1_fs_q  <= frame_start;
                s1_en_q  <= eff_en;
                if (frame_start) begin
                    en_active_q <= layer_en;
                end
            end
            if (s1_valid_q) begin
                pix_q     <= pix_d;
                top_q     <= win_idx;
                running_q <= running_d;
                if (s1_fs_q) begin
                    count_q <= running_q;
                    flag_q  <= (running_q != '0);
                end
            end
        end
    end

    assign pix_out         = pix_q;
    assign pix_valid_out   = s2_valid_q;
    assign top_layer       = top_q;
    assign collision_count = count_q;
    assign collision_flag  = flag_q;

endmodule
